// File: rtl/pipe_ctrl_regs_if.sv
// Bundle of ID-stage control inputs and EXE/MEM/WB control outputs of the
// pipeline control register chain.
interface pipe_ctrl_regs_if #(
    parameter int CNT_W = 16
);
    logic             id_wreg;
    logic             id_m2reg;
    logic             id_wmem;
    logic             id_regrt;
    logic             id_wz;
    logic [2:0]       id_aluc;
    logic [1:0]       id_alu_a_select;
    logic [1:0]       id_alu_b_select;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             stall_en;
    logic             flush;
    logic             alu_z;

    logic             exe_wreg;
    logic             exe_m2reg;
    logic             exe_wmem;
    logic             exe_wz;
    logic [2:0]       exe_aluc;
    logic [1:0]       exe_alu_a_select;
    logic [1:0]       exe_alu_b_select;
    logic [4:0]       exe_rd;
    logic             mem_wreg;
    logic             mem_m2reg;
    logic             mem_wmem;
    logic [4:0]       mem_rd;
    logic             wb_wreg;
    logic             wb_m2reg;
    logic [4:0]       wb_rd;
    logic             z;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_wreg, id_m2reg, id_wmem, id_regrt, id_wz, id_aluc,
               id_alu_a_select, id_alu_b_select, id_rt, id_rd,
               stall_en, flush, alu_z,
        output exe_wreg, exe_m2reg, exe_wmem, exe_wz, exe_aluc,
               exe_alu_a_select, exe_alu_b_select, exe_rd,
               mem_wreg, mem_m2reg, mem_wmem, mem_rd,
               wb_wreg, wb_m2reg, wb_rd, z, stall_cnt, flush_cnt
    );

    modport master (
        output id_wreg, id_m2reg, id_wmem, id_regrt, id_wz, id_aluc,
               id_alu_a_select, id_alu_b_select, id_rt, id_rd,
               stall_en, flush, alu_z,
        input  exe_wreg, exe_m2reg, exe_wmem, exe_wz, exe_aluc,
               exe_alu_a_select, exe_alu_b_select, exe_rd,
               mem_wreg, mem_m2reg, mem_wmem, mem_rd,
               wb_wreg, wb_m2reg, wb_rd, z, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_regs.sv
// ID->EXE->MEM->WB control register chain with bubble insertion, branch zero
// flag and saturating stall/flush event counters.
module pipe_ctrl_regs #(
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_regs_if.slave bus
);
    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       wz;
        logic [2:0] aluc;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [4:0] rd;
    } exe_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic [4:0] rd;
    } wb_t;

    exe_t             exe_q, exe_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic             z_q, z_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [4:0]       dest;

    always_comb begin
        dest  = bus.id_regrt ? bus.id_rt : bus.id_rd;
        exe_d = '0;
        if (!(bus.stall_en || bus.flush)) begin
            // r0 is hardwired; never let it look like a forwarding source
            exe_d.wreg  = bus.id_wreg && (dest != 5'd0);
            exe_d.m2reg = bus.id_m2reg;
            exe_d.wmem  = bus.id_wmem;
            exe_d.wz    = bus.id_wz;
            exe_d.aluc  = bus.id_aluc;
            exe_d.asel  = bus.id_alu_a_select;
            exe_d.bsel  = bus.id_alu_b_select;
            exe_d.rd    = dest;
        end

        mem_d = '{wreg: exe_q.wreg, m2reg: exe_q.m2reg, wmem: exe_q.wmem, rd: exe_q.rd};
        wb_d  = '{wreg: mem_q.wreg, m2reg: mem_q.m2reg, rd: mem_q.rd};
        z_d   = exe_q.wz ? bus.alu_z : z_q;

        stall_cnt_d = stall_cnt_q;
        if (bus.stall_en && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (bus.flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            z_q         <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            z_q         <= z_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.exe_wreg         = exe_q.wreg;
    assign bus.exe_m2reg        = exe_q.m2reg;
    assign bus.exe_wmem         = exe_q.wmem;
    assign bus.exe_wz           = exe_q.wz;
    assign bus.exe_aluc         = exe_q.aluc;
    assign bus.exe_alu_a_select = exe_q.asel;
    assign bus.exe_alu_b_select = exe_q.bsel;
    assign bus.exe_rd           = exe_q.rd;
    assign bus.mem_wreg         = mem_q.wreg;
    assign bus.mem_m2reg        = mem_q.m2reg;
    assign bus.mem_wmem         = mem_q.wmem;
    assign bus.mem_rd           = mem_q.rd;
    assign bus.wb_wreg          = wb_q.wreg;
    assign bus.wb_m2reg         = wb_q.m2reg;
    assign bus.wb_rd            = wb_q.rd;
    assign bus.z                = z_q;
    assign bus.stall_cnt        = stall_cnt_q;
    assign bus.flush_cnt        = flush_cnt_q;
endmodule

// File: doc/pipe_ctrl_regs.md
# pipe_ctrl_regs

Pipeline control register chain carrying decoded control fields from ID through EXE, MEM and WB. It produces the `exe_*` and `mem_*` destination and write-enable signals that the control unit uses for forwarding and load-use stall detection. It inserts bubbles on stall or flush, holds the branch zero flag, and keeps saturating stall/flush event counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of stall/flush event counters

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- id_wreg  input  1  ID register-write enable
- id_m2reg  input  1  ID load (memory-to-register) select
- id_wmem  input  1  ID memory write enable
- id_regrt  input  1  1: destination is rt, 0: destination is rd
- id_wz  input  1  ID instruction updates zero flag (beq/bne)
- id_aluc  input  3  ID ALU control code
- id_alu_a_select  input  2  ID ALU A operand/forward select
- id_alu_b_select  input  2  ID ALU B operand/forward select
- id_rt  input  5  rt field of ID instruction
- id_rd  input  5  rd field of ID instruction
- stall_en  input  1  load-use stall request from control unit
- flush  input  1  discard ID instruction (taken branch/jump)
- alu_z  input  1  EXE ALU zero result
- exe_wreg, exe_m2reg, exe_wmem, exe_wz  output  1 each  EXE control
- exe_aluc  output  3  EXE ALU control
- exe_alu_a_select, exe_alu_b_select  output  2 each  EXE operand selects
- exe_rd  output  5  EXE destination register
- mem_wreg, mem_m2reg, mem_wmem  output  1 each  MEM control
- mem_rd  output  5  MEM destination register
- wb_wreg, wb_m2reg  output  1 each  WB control
- wb_rd  output  5  WB destination register
- z  output  1  registered zero flag
- stall_cnt  output  CNT_W  stall cycles seen, saturating
- flush_cnt  output  CNT_W  flush cycles seen, saturating

## Operation
- Destination: `dest = id_regrt ? id_rt : id_rd`. If `dest == 0`, the EXE stage captures `wreg = 0`, because register 0 must never be forwarded or written.
- Each rising edge loads EXE, MEM and WB:
  - EXE: if `stall_en | flush`, EXE loads a bubble. Otherwise EXE loads all ID fields.
  - MEM: loads `exe_wreg`, `exe_m2reg`, `exe_wmem` and `exe_rd` unconditionally.
  - WB: loads `mem_wreg`, `mem_m2reg` and `mem_rd` unconditionally.
- Bubble: all enables 0 (`wreg`, `m2reg`, `wmem`, `wz`), `aluc = 3'b000`, selects `2'b00`, `rd = 0`.
- MEM and WB are never stalled. A bubble in EXE drains down the chain normally.
- Zero flag: on an edge where `exe_wz = 1`, `z <= alu_z`. Otherwise `z` holds its value.
- Counters:
  - `stall_cnt` increments on each edge with `stall_en = 1`.
  - `flush_cnt` increments on each edge with `flush = 1`.
  - Both saturate at all-ones and never wrap.
- Simultaneous `stall_en` and `flush`: a single bubble is inserted, and both counters increment.
- Control fields are stored exactly as given, with no decoding. The only exception is the `dest == 0` write-enable override.
- Stalling the PC and the IF/ID register is outside this block; the control unit's `stall_en` goes there directly.

## Timing
- Reset (async, immediate, regardless of clk): every output is 0, including `z`, both counters and all stage registers.
- Reset deassertion: the first rising edge with `rst = 0` captures ID normally.
- Reset asserted mid-operation: all in-flight instructions are discarded with no partial writes, and the counters clear.
- Latency: ID field to `exe_*` is 1 cycle, to `mem_*` 2 cycles, to `wb_*` 3 cycles.
- `z` is visible the cycle after the branch instruction sits in EXE.
- Load-use timing: `stall_en` high for one cycle means the next cycle shows `exe_wreg = 0` and `exe_rd = 0`. The load moves into MEM (`mem_m2reg = 1`) in that same cycle.
- No combinational paths from inputs to outputs; every output is a flop.

## Test plan
- **Reset:** drive nonzero ID fields, assert `rst` between edges → all outputs 0 immediately. Release `rst`; the next edge gives `exe_*` equal to the ID values.
- **Propagation:** `id_wreg = 1`, `id_regrt = 0`, `id_rd = 5`, `id_aluc = 3'b010`, then zeros → `exe_rd = 5` at T+1, `mem_rd = 5` at T+2, `wb_rd = 5` and `wb_wreg = 1` at T+3.
- **Load-use:** lw with `id_regrt = 1`, `id_rt = 7`, `id_m2reg = 1`, followed by `stall_en = 1` for one cycle → bubble in EXE (`exe_wreg = 0`, `exe_rd = 0`) while `mem_rd = 7` and `mem_m2reg = 1`. `stall_cnt = 1`.
- **r0 suppression:** `id_wreg = 1`, `id_rd = 0` → `exe_wreg = 0`, `mem_wreg = 0`, `wb_wreg = 0`.
- **Zero flag and flush:**
  - beq in EXE with `exe_wz = 1` and `alu_z = 1` → `z = 1` next cycle. A non-branch with `alu_z = 0` leaves `z = 1`.
  - `flush = 1` with `stall_en = 1` → one bubble, `flush_cnt` and `stall_cnt` each increment by 1.
- **Saturation:** with CNT_W = 4, hold `stall_en = 1` for 20 cycles → `stall_cnt` stops at 15.
